// File: rtl/calc_arbiter_if.sv
// Request/response and calculator-side signal bundle for calc_arbiter.
// slave is the arbiter's view; master is the view of clients plus calculator.
interface calc_arbiter_if #(
    parameter int unsigned ANCHO = 8
);
    logic             req0_valid;
    logic             req0_ready;
    logic [ANCHO-1:0] req0_a;
    logic [ANCHO-1:0] req0_b;
    logic [1:0]       req0_modo;

    logic             req1_valid;
    logic             req1_ready;
    logic [ANCHO-1:0] req1_a;
    logic [ANCHO-1:0] req1_b;
    logic [1:0]       req1_modo;

    logic             rsp0_valid;
    logic             rsp1_valid;
    logic [ANCHO-1:0] rsp_data;

    logic             calc_en;
    logic [ANCHO-1:0] calc_a;
    logic [ANCHO-1:0] calc_b;
    logic [1:0]       calc_modo;
    logic [ANCHO-1:0] calc_c;

    logic             busy;

    modport slave (
        input  req0_valid, req0_a, req0_b, req0_modo,
        input  req1_valid, req1_a, req1_b, req1_modo,
        input  calc_c,
        output req0_ready, req1_ready,
        output rsp0_valid, rsp1_valid, rsp_data,
        output calc_en, calc_a, calc_b, calc_modo,
        output busy
    );

    modport master (
        output req0_valid, req0_a, req0_b, req0_modo,
        output req1_valid, req1_a, req1_b, req1_modo,
        output calc_c,
        input  req0_ready, req1_ready,
        input  rsp0_valid, rsp1_valid, rsp_data,
        input  calc_en, calc_a, calc_b, calc_modo,
        input  busy
    );
endinterface

// File: rtl/calc_arbiter.sv
// Round-robin arbiter/sequencer in front of the shared calculator: grants one of two
// requesters, runs the calculator for LATENCIA cycles, and returns the captured result.
module calc_arbiter #(
    parameter int unsigned LATENCIA = 2,
    parameter int unsigned ANCHO    = 8
) (
    input logic           clk,
    input logic           rst,
    calc_arbiter_if.slave bus
);

    typedef enum logic [1:0] {StIdle, StBusy, StCapture} state_e;

    localparam logic [3:0] LastCnt = 4'(LATENCIA - 1);

    state_e           state_q, state_d;
    logic             turno_q, turno_d;
    logic             owner_q, owner_d;
    logic [3:0]       cnt_q, cnt_d;
    logic [ANCHO-1:0] a_q, a_d;
    logic [ANCHO-1:0] b_q, b_d;
    logic [1:0]       modo_q, modo_d;
    logic [ANCHO-1:0] data_q, data_d;
    logic             rsp0_q, rsp0_d;
    logic             rsp1_q, rsp1_d;
    logic             grant0, grant1;

    // A lone requester always wins; turno only breaks ties.
    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (state_q == StIdle) begin
            if (bus.req0_valid && (!bus.req1_valid || !turno_q)) begin
                grant0 = 1'b1;
            end else if (bus.req1_valid) begin
                grant1 = 1'b1;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        turno_d = turno_q;
        owner_d = owner_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        modo_d  = modo_q;
        data_d  = data_q;
        rsp0_d  = 1'b0;
        rsp1_d  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (grant0 || grant1) begin
                    a_d     = grant1 ? bus.req1_a : bus.req0_a;
                    b_d     = grant1 ? bus.req1_b : bus.req0_b;
                    modo_d  = grant1 ? bus.req1_modo : bus.req0_modo;
                    owner_d = grant1;
                    turno_d = ~grant1;
                    cnt_d   = '0;
                    state_d = StBusy;
                end
            end
            StBusy: begin
                cnt_d = cnt_q + 4'd1;
                if (cnt_q == LastCnt) begin
                    state_d = StCapture;
                end
            end
            StCapture: begin
                data_d  = bus.calc_c;
                rsp0_d  = ~owner_q;
                rsp1_d  = owner_q;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StIdle;
            turno_q <= 1'b0;
            owner_q <= 1'b0;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            modo_q  <= '0;
            data_q  <= '0;
            rsp0_q  <= 1'b0;
            rsp1_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            turno_q <= turno_d;
            owner_q <= owner_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            modo_q  <= modo_d;
            data_q  <= data_d;
            rsp0_q  <= rsp0_d;
            rsp1_q  <= rsp1_d;
        end
    end

    assign bus.req0_ready = grant0;
    assign bus.req1_ready = grant1;
    assign bus.rsp0_valid = rsp0_q;
    assign bus.rsp1_valid = rsp1_q;
    assign bus.rsp_data   = data_q;
    // Enable only while BUSY so the calculator's output register holds through CAPTURE.
    assign bus.calc_en    = (state_q == StBusy);
    assign bus.calc_a     = a_q;
    assign bus.calc_b     = b_q;
    assign bus.calc_modo  = modo_q;
    assign bus.busy       = (state_q != StIdle);

endmodule

// File: tb/tb_calc_arbiter.sv
// Bench for calc_arbiter: calculator model plus a grant/response reference model,
// directed scenarios followed by a randomized request stream.
module tb_calc_arbiter;
    localparam int unsigned LAT = 2;
    localparam int unsigned W   = 8;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    calc_arbiter_if #(.ANCHO(W)) bus ();

    calc_arbiter #(.LATENCIA(LAT), .ANCHO(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_checks = 0;
    int n_err    = 0;
    int cyc      = 0;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [W-1:0] calc_ref(input logic [W-1:0] a, input logic [W-1:0] b,
                                              input logic [1:0] m);
        logic [W-1:0] r;
        case (m)
            2'd0:    r = a + b;
            2'd1:    r = a - b;
            2'd2:    r = a * b;
            default: r = a << b;
        endcase
        return r;
    endfunction

    // Calculator: LAT-deep pipeline that only advances while en is high.
    logic [W-1:0] pipe [LAT];
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < LAT; i++) pipe[i] <= '0;
        end else if (bus.calc_en) begin
            pipe[0] <= calc_ref(bus.calc_a, bus.calc_b, bus.calc_modo);
            for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
        end
    end
    assign bus.calc_c = pipe[LAT-1];

    // Reference model state
    bit           pref      = 1'b0;
    int           due       = -1;
    bit           due_owner = 1'b0;
    logic [W-1:0] due_data  = '0;
    logic [W-1:0] last_data = '0;
    bit           obs_w     = 1'b0;
    bit           wins [6];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_rsp();
        bit e0, e1;
        e0 = (cyc == due) && !due_owner;
        e1 = (cyc == due) && due_owner;
        chk("rsp0_valid", 32'(bus.rsp0_valid), 32'(e0));
        chk("rsp1_valid", 32'(bus.rsp1_valid), 32'(e1));
        if (cyc == due) begin
            last_data = due_data;
            due = -1;
        end
        chk("rsp_data", 32'(bus.rsp_data), 32'(last_data));
    endtask

    task automatic drop_valids();
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            drop_valids();
            @(negedge clk);
            chk("idle_ready0", 32'(bus.req0_ready), 32'd0);
            chk("idle_ready1", 32'(bus.req1_ready), 32'd0);
            chk("idle_busy", 32'(bus.busy), 32'd0);
            chk("idle_en", 32'(bus.calc_en), 32'd0);
            chk_rsp();
            @(posedge clk); #1;
        end
    endtask

    task automatic do_reset();
        rst = 1'b0;
        pref = 1'b0;
        due = -1;
        last_data = '0;
        drop_valids();
        @(negedge clk);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_en", 32'(bus.calc_en), 32'd0);
        chk("rst_calc_a", 32'(bus.calc_a), 32'd0);
        chk("rst_calc_modo", 32'(bus.calc_modo), 32'd0);
        chk_rsp();
        @(posedge clk); #1;
        rst = 1'b1;
    endtask

    // Entered and left #1 after a rising edge; returns positioned in the response cycle.
    task automatic op(input bit v0, input logic [W-1:0] a0, input logic [W-1:0] b0,
                      input logic [1:0] m0, input bit v1, input logic [W-1:0] a1,
                      input logic [W-1:0] b1, input logic [1:0] m1, input bit hold);
        bit w;
        logic [W-1:0] ea, eb;
        logic [1:0] em;
        bus.req0_valid = v0; bus.req0_a = a0; bus.req0_b = b0; bus.req0_modo = m0;
        bus.req1_valid = v1; bus.req1_a = a1; bus.req1_b = b1; bus.req1_modo = m1;
        w  = (v0 && v1) ? pref : v1;
        ea = w ? a1 : a0;
        eb = w ? b1 : b0;
        em = w ? m1 : m0;
        @(negedge clk);
        chk("grant_ready0", 32'(bus.req0_ready), 32'(!w));
        chk("grant_ready1", 32'(bus.req1_ready), 32'(w));
        chk("grant_busy", 32'(bus.busy), 32'd0);
        chk_rsp();
        obs_w = bus.req1_ready;
        pref = !w;
        due = cyc + LAT + 2;
        due_owner = w;
        due_data = calc_ref(ea, eb, em);
        @(posedge clk); #1;
        for (int i = 0; i <= LAT; i++) begin
            bus.req0_a = W'($urandom); bus.req0_b = W'($urandom); bus.req0_modo = 2'($urandom);
            bus.req1_a = W'($urandom); bus.req1_b = W'($urandom); bus.req1_modo = 2'($urandom);
            if (!hold) drop_valids();
            @(negedge clk);
            chk("op_en", 32'(bus.calc_en), (i < LAT) ? 32'd1 : 32'd0);
            chk("op_busy", 32'(bus.busy), 32'd1);
            chk("op_calc_a", 32'(bus.calc_a), 32'(ea));
            chk("op_calc_b", 32'(bus.calc_b), 32'(eb));
            chk("op_calc_modo", 32'(bus.calc_modo), 32'(em));
            chk("op_ready0", 32'(bus.req0_ready), 32'd0);
            chk("op_ready1", 32'(bus.req1_ready), 32'd0);
            chk_rsp();
            @(posedge clk); #1;
        end
    endtask

    initial begin
        drop_valids();
        bus.req0_a = '0; bus.req0_b = '0; bus.req0_modo = '0;
        bus.req1_a = '0; bus.req1_b = '0; bus.req1_modo = '0;
        @(posedge clk); #1;
        do_reset();
        idle(1);

        // Single suma from requester 0
        op(1'b1, 8'd5, 8'd3, 2'd0, 1'b0, 8'd0, 8'd0, 2'd0, 1'b0);
        idle(1);
        chk("suma_5_3", 32'(bus.rsp_data), 32'd8);

        // Simultaneous requests after reset: requester 0 first, then 1 back-to-back
        do_reset();
        op(1'b1, 8'd10, 8'd4, 2'd1, 1'b1, 8'd3, 8'd4, 2'd2, 1'b1);
        op(1'b1, 8'd10, 8'd4, 2'd1, 1'b1, 8'd3, 8'd4, 2'd2, 1'b1);
        chk("simul_second_owner", 32'(obs_w), 32'd1);
        idle(1);
        chk("mult_3_4", 32'(bus.rsp_data), 32'd12);

        // Fairness: both valid continuously for six grants
        for (int i = 0; i < 6; i++) begin
            op(1'b1, W'($urandom), W'($urandom), 2'($urandom),
               1'b1, W'($urandom), W'($urandom), 2'($urandom), 1'b1);
            wins[i] = obs_w;
        end
        idle(1);
        for (int i = 1; i < 6; i++) chk("fair_alternate", 32'(wins[i]), 32'(!wins[i-1]));

        // Lone requester 1 twice in a row, truncated multiply
        op(1'b0, 8'd0, 8'd0, 2'd0, 1'b1, 8'd20, 8'd20, 2'd2, 1'b1);
        op(1'b0, 8'd0, 8'd0, 2'd0, 1'b1, 8'd20, 8'd20, 2'd2, 1'b1);
        chk("lone_second_owner", 32'(obs_w), 32'd1);
        idle(1);
        chk("mult_trunc", 32'(bus.rsp_data), 32'h90);

        // Reset during the second BUSY cycle aborts the operation
        bus.req0_valid = 1'b1; bus.req0_a = 8'd7; bus.req0_b = 8'd9; bus.req0_modo = 2'd0;
        @(negedge clk);
        chk("abort_ready0", 32'(bus.req0_ready), 32'd1);
        chk_rsp();
        @(posedge clk); #1;
        drop_valids();
        @(negedge clk);
        chk("abort_en_busy1", 32'(bus.calc_en), 32'd1);
        @(posedge clk); #2;
        rst = 1'b0;
        pref = 1'b0;
        due = -1;
        last_data = '0;
        #1;
        chk("abort_en", 32'(bus.calc_en), 32'd0);
        chk("abort_busy", 32'(bus.busy), 32'd0);
        chk("abort_rsp0", 32'(bus.rsp0_valid), 32'd0);
        chk("abort_rsp1", 32'(bus.rsp1_valid), 32'd0);
        chk("abort_data", 32'(bus.rsp_data), 32'd0);
        @(posedge clk); #1;
        rst = 1'b1;
        idle(4);
        op(1'b1, 8'd1, 8'd1, 2'd0, 1'b0, 8'd0, 8'd0, 2'd0, 1'b0);
        idle(1);
        chk("after_abort_suma", 32'(bus.rsp_data), 32'd2);

        // Randomized request stream with random gaps and held valids
        for (int i = 0; i < 24; i++) begin
            bit rv0, rv1;
            rv0 = 1'($urandom_range(0, 1));
            rv1 = 1'($urandom_range(0, 1));
            if (!rv0 && !rv1) rv0 = 1'b1;
            op(rv0, W'($urandom), W'($urandom), 2'($urandom),
               rv1, W'($urandom), W'($urandom), 2'($urandom), 1'($urandom_range(0, 1)));
            idle($urandom_range(0, 2));
        end
        idle(2);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
